// File: rtl/decoder_3_to_8_seq.sv
// ----------------------------------------------------------------------------
// decoder_3_to_8_seq
//
// Registered 3:8 decoder with a valid/ready input handshake and a
// pulse-stretching output sequencer. An accepted 3-bit code drives the
// matching one-hot line for PULSE_CYCLES cycles. The output then stays
// all-zero for GAP_CYCLES cycles before the block accepts another code.
//
// Optional feature macro: DEC_CNT_EN
//   When defined, this block adds the o_cnt port. o_cnt is a saturating
//   count of accepted codes and is cleared only by reset.
//
// Ports:
//   i_clk    - clock, rising edge
//   i_rst_n  - asynchronous active-low reset
//   i_en     - enable; low aborts any pulse and blocks acceptance
//   i_valid  - i_code is valid this cycle
//   i_code   - binary index 0..7
//   o_ready  - block can accept a code this cycle
//   o_y      - registered one-hot output (zero outside a pulse)
//   o_valid  - high while o_y carries a pulse
//   o_busy   - high while a pulse or its guard gap is in progress
//   o_cnt    - accepted-code count (DEC_CNT_EN only)
// ----------------------------------------------------------------------------
module decoder_3_to_8_seq #(
    parameter int unsigned PULSE_CYCLES = 4,
    parameter int unsigned GAP_CYCLES   = 1,
    parameter int unsigned CNT_W        = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_valid,
    input  logic [2:0]       i_code,
    output logic             o_ready,
    output logic [7:0]       o_y,
    output logic             o_valid,
    output logic             o_busy
`ifdef DEC_CNT_EN
    ,
    output logic [CNT_W-1:0] o_cnt
`endif
);

    // The timer only has to hold PULSE_CYCLES-1 or GAP_CYCLES-1. The floor of
    // 2 keeps its width at one bit or more.
    localparam int unsigned MAX_PG = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int unsigned MAX_T  = (MAX_PG > 2) ? MAX_PG : 2;
    localparam int unsigned TW     = $clog2(MAX_T);

    localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD   = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [TW-1:0] r_tmr;
    logic [TW-1:0] w_tmr_nxt;
    logic [7:0]    r_y;
    logic [7:0]    w_y_nxt;
    logic          r_valid;
    logic          w_valid_nxt;
    logic          w_ready;
    logic          w_accept;

    // Ready depends only on registered state and the enable. i_valid never
    // reaches it.
    assign w_ready  = (r_state == S_IDLE) && i_en;
    assign w_accept = w_ready && i_valid;

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr;
        w_y_nxt     = r_y;
        w_valid_nxt = r_valid;
        if (!i_en) begin
            // Abort from any state.
            w_state_nxt = S_IDLE;
            w_tmr_nxt   = '0;
            w_y_nxt     = 8'h00;
            w_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        w_state_nxt = S_HOLD;
                        w_tmr_nxt   = PULSE_LOAD;
                        w_y_nxt     = 8'h01 << i_code;
                        w_valid_nxt = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (r_tmr != '0) begin
                        w_tmr_nxt = r_tmr - TW'(1);
                    end else begin
                        w_y_nxt     = 8'h00;
                        w_valid_nxt = 1'b0;
                        if (GAP_CYCLES > 0) begin
                            w_state_nxt = S_GAP;
                            w_tmr_nxt   = GAP_LOAD;
                        end else begin
                            w_state_nxt = S_IDLE;
                            w_tmr_nxt   = '0;
                        end
                    end
                end
                S_GAP: begin
                    if (r_tmr != '0) begin
                        w_tmr_nxt = r_tmr - TW'(1);
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_tmr_nxt   = '0;
                    w_y_nxt     = 8'h00;
                    w_valid_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_tmr   <= '0;
            r_y     <= 8'h00;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tmr   <= w_tmr_nxt;
            r_y     <= w_y_nxt;
            r_valid <= w_valid_nxt;
        end
    end

`ifdef DEC_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    // Saturating count. i_en does not clear it; only reset does.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (w_accept && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;
`endif

    assign o_ready = w_ready;
    assign o_y     = r_y;
    assign o_valid = r_valid;
    assign o_busy  = (r_state == S_HOLD) || (r_state == S_GAP);

endmodule

// File: tb/tb_decoder_3_to_8_seq.sv
// ----------------------------------------------------------------------------
// tb_decoder_3_to_8_seq
//
// Self-checking bench for decoder_3_to_8_seq with its default parameters.
// The reference model records only when the last code was accepted and which
// code it was. Every expected output comes from how many edges have elapsed
// since that accept. When DEC_CNT_EN is defined, the bench also checks o_cnt.
// ----------------------------------------------------------------------------
module tb_decoder_3_to_8_seq;

    localparam int P     = 4;
    localparam int G     = 1;
    localparam int CNT_W = 8;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_en;
    logic       i_valid;
    logic [2:0] i_code;
    logic       o_ready;
    logic [7:0] o_y;
    logic       o_valid;
    logic       o_busy;
`ifdef DEC_CNT_EN
    logic [CNT_W-1:0] o_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    decoder_3_to_8_seq #(
        .PULSE_CYCLES(P),
        .GAP_CYCLES  (G),
        .CNT_W       (CNT_W)
    ) u_dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_en   (i_en),
        .i_valid(i_valid),
        .i_code (i_code),
        .o_ready(o_ready),
        .o_y    (o_y),
        .o_valid(o_valid),
        .o_busy (o_busy)
`ifdef DEC_CNT_EN
        ,
        .o_cnt  (o_cnt)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Reference model: edge counter, edge index of the last accept, and its code.
    int         cyc;
    int         t_acc;
    logic       m_act;
    logic [2:0] m_code;
    int         m_cnt;

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cyc   <= 0;
            t_acc <= 0;
            m_act <= 1'b0;
            m_code <= 3'd0;
            m_cnt <= 0;
        end else begin
            cyc <= cyc + 1;
            if (!i_en) begin
                m_act <= 1'b0;
            end else if (i_valid && !(m_act && (cyc - t_acc) < P + G)) begin
                m_act  <= 1'b1;
                t_acc  <= cyc + 1;
                m_code <= i_code;
                if (m_cnt < (1 << CNT_W) - 1) m_cnt <= m_cnt + 1;
            end
        end
    end

    // Expected {o_y, o_valid, o_busy, o_ready} for the current cycle.
    function automatic logic [10:0] exp_vec();
        int   d;
        logic pulse;
        logic busy;
        d     = cyc - t_acc;
        pulse = m_act && (d < P);
        busy  = m_act && (d < P + G);
        return {pulse ? (8'h01 << m_code) : 8'h00, pulse, busy, i_en && !busy};
    endfunction

    function automatic logic just_accepted(input logic [2:0] c);
        return m_act && (cyc == t_acc) && (m_code == c);
    endfunction

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_en    = 1'b1;
        i_valid = 1'b0;
        i_code  = 3'd0;
        #12;
        n_checks++;
        if ({o_y, o_valid, o_busy} !== 10'h000)
            $display("FAIL reset_asserted: got y=%h v=%b b=%b want 00/0/0", o_y, o_valid, o_busy);
        else n_pass++;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        n_checks++;
        if ({o_y, o_valid, o_busy, o_ready} !== {8'h00, 1'b0, 1'b0, 1'b1})
            $display("FAIL reset_idle: got y=%h v=%b b=%b r=%b want 00/0/0/1",
                     o_y, o_valid, o_busy, o_ready);
        else n_pass++;
`ifdef DEC_CNT_EN
        n_checks++;
        if (o_cnt !== '0) $display("FAIL reset_cnt: got %0d want 0", o_cnt);
        else n_pass++;
`endif
    endtask

    task automatic test_single_code5();
        logic [10:0] got;
        logic [10:0] exp;
        int          n_hi;
        int          n_gap;
        n_hi  = 0;
        n_gap = 0;
        i_valid = 1'b1;
        i_code  = 3'd5;
        for (int i = 0; i < 10; i++) begin
            @(negedge i_clk);
            got = {o_y, o_valid, o_busy, o_ready};
            exp = exp_vec();
            n_checks++;
            if (got !== exp) $display("FAIL single_cycle%0d: got %h want %h", i, got, exp);
            else n_pass++;
            if (o_y == 8'h20) n_hi++;
            if (o_y == 8'h00 && o_busy) n_gap++;
            if (i == 0) begin
                n_checks++;
                if (o_y !== 8'h20) $display("FAIL single_latency: got %h want 20", o_y);
                else n_pass++;
                i_valid = 1'b0;
            end
        end
        n_checks++;
        if (n_hi != P) $display("FAIL single_width: got %0d want %0d", n_hi, P);
        else n_pass++;
        n_checks++;
        if (n_gap != G) $display("FAIL single_gap: got %0d want %0d", n_gap, G);
        else n_pass++;
        n_checks++;
        if (o_ready !== 1'b1) $display("FAIL single_ready_after: got %b want 1", o_ready);
        else n_pass++;
    endtask

    task automatic test_sweep();
        logic [10:0] got;
        logic [10:0] exp;
        logic [7:0]  obs [8];
        logic [7:0]  want;
        logic        done;
        int          cnt0;
        cnt0 = m_cnt;
        for (int c = 0; c < 8; c++) begin
            i_valid = 1'b1;
            i_code  = 3'(c);
            done    = 1'b0;
            obs[c]  = 8'hxx;
            for (int k = 0; k < 20 && !done; k++) begin
                @(negedge i_clk);
                got = {o_y, o_valid, o_busy, o_ready};
                exp = exp_vec();
                n_checks++;
                if (got !== exp) $display("FAIL sweep_code%0d: got %h want %h", c, got, exp);
                else n_pass++;
                n_checks++;
                if ($countones(o_y) > 1) $display("FAIL sweep_onehot: got %h want <=1 bit", o_y);
                else n_pass++;
                if (just_accepted(3'(c))) begin
                    obs[c] = o_y;
                    done   = 1'b1;
                end
            end
            if (!done) begin
                n_checks++;
                $display("FAIL sweep_timeout: code %0d not accepted, got none want accept", c);
            end
        end
        i_valid = 1'b0;
        for (int k = 0; k < P + G + 2; k++) begin
            @(negedge i_clk);
            got = {o_y, o_valid, o_busy, o_ready};
            exp = exp_vec();
            n_checks++;
            if (got !== exp) $display("FAIL sweep_drain: got %h want %h", got, exp);
            else n_pass++;
        end
        for (int c = 0; c < 8; c++) begin
            want = 8'h01 << c;
            n_checks++;
            if (obs[c] !== want) $display("FAIL sweep_seq%0d: got %h want %h", c, obs[c], want);
            else n_pass++;
        end
`ifdef DEC_CNT_EN
        n_checks++;
        if (int'(o_cnt) - cnt0 != 8)
            $display("FAIL sweep_cnt: got delta %0d want 8", int'(o_cnt) - cnt0);
        else n_pass++;
`endif
    endtask

    task automatic test_hold_ignore();
        logic [10:0] got;
        logic [10:0] exp;
        int          n_04;
        int          t_first;
        int          t_second;
        n_04     = 0;
        t_first  = -1;
        t_second = -1;
        i_valid  = 1'b1;
        i_code   = 3'd2;
        for (int k = 0; k < 14; k++) begin
            @(negedge i_clk);
            got = {o_y, o_valid, o_busy, o_ready};
            exp = exp_vec();
            n_checks++;
            if (got !== exp) $display("FAIL hold_cycle%0d: got %h want %h", k, got, exp);
            else n_pass++;
            if (o_y == 8'h04) n_04++;
            if (t_first < 0 && just_accepted(3'd2)) begin
                t_first = cyc;
                i_code  = 3'd7;
            end else if (t_second < 0 && just_accepted(3'd7)) begin
                t_second = cyc;
                i_valid  = 1'b0;
            end
        end
        i_valid = 1'b0;
        n_checks++;
        if (n_04 != P) $display("FAIL hold_width: got %0d want %0d", n_04, P);
        else n_pass++;
        n_checks++;
        if (t_first < 0 || t_second - t_first != P + G + 1)
            $display("FAIL hold_spacing: got %0d want %0d", t_second - t_first, P + G + 1);
        else n_pass++;
        repeat (P + G + 2) @(negedge i_clk);
    endtask

    task automatic test_en_abort();
        logic [10:0] got;
        logic [10:0] exp;
        i_valid = 1'b1;
        i_code  = 3'd6;
        @(negedge i_clk);
        i_valid = 1'b0;
        n_checks++;
        if (o_y !== 8'h40) $display("FAIL abort_first_hold: got %h want 40", o_y);
        else n_pass++;
        @(negedge i_clk);
        i_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            got = {o_y, o_valid, o_busy, o_ready};
            exp = exp_vec();
            n_checks++;
            if (got !== {8'h00, 1'b0, 1'b0, 1'b0})
                $display("FAIL abort_idle%0d: got %h want 000", k, got);
            else n_pass++;
            n_checks++;
            if (got !== exp) $display("FAIL abort_model%0d: got %h want %h", k, got, exp);
            else n_pass++;
        end
        i_en    = 1'b1;
        i_valid = 1'b1;
        i_code  = 3'd1;
        #1;
        n_checks++;
        if (o_ready !== 1'b1) $display("FAIL abort_reenable_ready: got %b want 1", o_ready);
        else n_pass++;
        @(negedge i_clk);
        i_valid = 1'b0;
        n_checks++;
        if (o_y !== 8'h02) $display("FAIL abort_next_code: got %h want 02", o_y);
        else n_pass++;
        repeat (P + G + 2) @(negedge i_clk);
    endtask

    task automatic test_async_reset();
        i_valid = 1'b1;
        i_code  = 3'd3;
        @(negedge i_clk);
        i_valid = 1'b0;
        @(negedge i_clk);
        n_checks++;
        if (o_y !== 8'h08) $display("FAIL areset_pre: got %h want 08", o_y);
        else n_pass++;
        #2 i_rst_n = 1'b0;
        #1;
        n_checks++;
        if ({o_y, o_valid, o_busy} !== 10'h000)
            $display("FAIL areset_immediate: got y=%h v=%b b=%b want 00/0/0", o_y, o_valid, o_busy);
        else n_pass++;
`ifdef DEC_CNT_EN
        n_checks++;
        if (o_cnt !== '0) $display("FAIL areset_cnt: got %0d want 0", o_cnt);
        else n_pass++;
`endif
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        n_checks++;
        if (o_ready !== 1'b1 || o_y !== 8'h00)
            $display("FAIL areset_release: got r=%b y=%h want 1/00", o_ready, o_y);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [10:0] got;
        logic [10:0] exp;
        for (int k = 0; k < 400; k++) begin
            i_en    = ($urandom_range(0, 9) != 0);
            i_valid = 1'($urandom_range(0, 1));
            i_code  = 3'($urandom);
            @(negedge i_clk);
            got = {o_y, o_valid, o_busy, o_ready};
            exp = exp_vec();
            n_checks++;
            if (got !== exp) $display("FAIL random_cycle%0d: got %h want %h", k, got, exp);
            else n_pass++;
            n_checks++;
            if ($countones(o_y) > 1) $display("FAIL random_onehot: got %h want <=1 bit", o_y);
            else n_pass++;
`ifdef DEC_CNT_EN
            n_checks++;
            if (int'(o_cnt) != m_cnt) $display("FAIL random_cnt: got %0d want %0d", o_cnt, m_cnt);
            else n_pass++;
`endif
        end
        i_en    = 1'b1;
        i_valid = 1'b0;
        repeat (P + G + 2) @(negedge i_clk);
    endtask

`ifdef DEC_CNT_EN
    task automatic test_cnt_saturate();
        i_valid = 1'b1;
        for (int k = 0; k < 260 * (P + G + 1) + 10; k++) begin
            i_code = 3'($urandom);
            @(negedge i_clk);
        end
        i_valid = 1'b0;
        n_checks++;
        if (o_cnt !== {CNT_W{1'b1}})
            $display("FAIL cnt_saturate: got %0d want %0d", o_cnt, (1 << CNT_W) - 1);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_single_code5();
        test_sweep();
        test_hold_ignore();
        test_en_abort();
        test_async_reset();
        test_random();
`ifdef DEC_CNT_EN
        test_cnt_saturate();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/decoder_3_to_8_seq.md
Name: decoder_3_to_8_seq

Overview:
Registered 3:8 decoder with a valid/ready input handshake and a pulse-stretching output sequencer. It accepts a 3-bit binary code, holds the matching one-hot line for a fixed number of cycles, then observes a guard gap before accepting the next code. It is the receive-side counterpart to the 8:3 encoder: encoded index in, one-hot strobe out, used to fan a binary select back out to eight enable lines.

Parameters:
PULSE_CYCLES, 4, cycles each one-hot output is held high (legal range >=1)
GAP_CYCLES, 1, cycles of all-zero output after each pulse before o_ready reasserts (legal range >=0)
CNT_W, 8, width of the optional accepted-code counter

Ports:
i_clk  input  1  clock, all state updates on the rising edge
i_rst_n  input  1  asynchronous active-low reset
i_en  input  1  enable; low aborts any pulse and blocks acceptance
i_valid  input  1  i_code is valid this cycle
i_code  input  3  binary index 0..7 to decode
o_ready  output  1  block can accept a code this cycle
o_y  output  8  registered one-hot output; bit k high means code k
o_valid  output  1  high while o_y carries a pulse (HOLD state)
o_busy  output  1  high in HOLD or GAP
o_cnt  output  CNT_W  accepted-code count (only when DEC_CNT_EN is defined)

Behaviour:
- Reset (i_rst_n low, asynchronous): state=IDLE, o_y=8'h00, o_valid=0, o_busy=0, hold/gap counter=0, o_cnt=0. Reset asserted mid-pulse clears o_y immediately, without waiting for a clock edge.
- States: IDLE, HOLD, GAP.
- o_ready = (state==IDLE) && i_en. This is combinational from registered state. i_valid has no combinational path to o_ready.
- Accept: rising edge with i_valid && o_ready. At that edge: o_y <= 1<<i_code, o_valid <= 1, state <= HOLD, counter <= PULSE_CYCLES-1. Latency is 1 cycle from the accept edge to o_y.
- HOLD: o_y is stable and o_valid=1.
  - counter!=0: decrement.
  - counter==0: o_y <= 0 and o_valid <= 0.
  - counter==0 and GAP_CYCLES>0: state <= GAP, counter <= GAP_CYCLES-1.
  - counter==0 and GAP_CYCLES==0: state <= IDLE.
  - The pulse is therefore exactly PULSE_CYCLES cycles wide.
- GAP: o_y=0. Decrement the counter; at 0, state <= IDLE. The all-zero gap is exactly GAP_CYCLES cycles.
- Back-to-back codes with GAP_CYCLES=0: a new code can be accepted on the edge where state returns to IDLE plus one cycle. The minimum accept spacing is PULSE_CYCLES+GAP_CYCLES+1 cycles.
- i_valid while not ready: ignored. The code is not queued, and the producer must hold it until accepted.
- i_en low in any state: at the next edge, state <= IDLE, o_y <= 0, o_valid <= 0, counter <= 0. No accept occurs while i_en is low.
- i_en rising: acceptance is possible from that same cycle, provided state is IDLE.
- o_y is always either zero or exactly one-hot. It never has multiple bits set.
- Counter width is clog2(max(PULSE_CYCLES,GAP_CYCLES,2)). No wrap is possible because the counter is reloaded before underflow.

Optional Feature:
DEC_CNT_EN
- Defined: the o_cnt port exists. It increments by 1 on every accept edge and saturates at 2^CNT_W-1. It is cleared only by reset; i_en low does not clear it.
- Undefined: the o_cnt port and its register are absent. All other behaviour is identical.

Test Plan:
- Reset release, i_en=1, idle -> o_y=8'h00, o_valid=0, o_ready=1, o_busy=0.
- Defaults (PULSE_CYCLES=4, GAP_CYCLES=1), accept i_code=3'd5 -> o_y=8'h20 for exactly 4 cycles starting 1 cycle after accept, then 1 cycle of 8'h00 with o_busy=1, then o_ready=1.
- Sweep codes 0..7, each accepted as soon as o_ready is high -> o_y sequence 01,02,04,08,10,20,40,80, each held 4 cycles. Every cycle is checked with $countones(o_y)<=1. With DEC_CNT_EN defined, o_cnt=8.
- i_valid held high with i_code=3'd7 during HOLD of a code-2 pulse -> no second accept until o_ready returns. o_y=8'h04 is unchanged throughout the hold.
- i_en deasserted on the 2nd HOLD cycle of code 6 -> next edge gives o_y=0, state IDLE. o_ready stays 0 until i_en=1, then code 1 is accepted normally (o_y=8'h02).
- Async reset pulsed mid-HOLD between clock edges -> o_y=0 immediately. With DEC_CNT_EN, o_cnt=0. CNT_W=2 with 5 accepts -> o_cnt saturates at 3.
